// File: rtl/dll_pkg.sv
// rtl/dll_pkg.sv - shared types and constants for the data-link transmit sequencer
// Purpose: sequence width, ACK/NAK encodings, FSM state encoding and CRC-16 constants.
// Ports: none (package).
package dll_pkg;

  localparam int SEQ_W = 12;

  typedef enum logic [1:0] {
    AN_NONE = 2'b00,
    AN_ACK  = 2'b01,
    AN_NAK  = 2'b10,
    AN_RSVD = 2'b11
  } ack_nak_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_CRC  = 2'd3
  } state_e;

  // CRC-16-CCITT, MSB first
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

endpackage

// File: rtl/dll_crc16.sv
// rtl/dll_crc16.sv - combinational one-word CRC-16-CCITT update
// Purpose: folds one 16-bit word (MSB first) into a running CRC-16-CCITT.
// Ports: crc_in  - running CRC before this word
//        data    - word to fold in
//        crc_out - running CRC after this word
module dll_crc16
  import dll_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [15:0] data,
  output logic [15:0] crc_out
);

  logic fb;

  always_comb begin
    fb      = 1'b0;
    crc_out = crc_in;
    for (int i = 15; i >= 0; i--) begin
      fb      = crc_out[15] ^ data[i];
      crc_out = {crc_out[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/dll_tx_seq.sv
// rtl/dll_tx_seq.sv - data-link TX sequencer: seq header insertion and ACK/NAK window
// Purpose: takes TLP words from the transaction layer, writes {header, data...} into the
//   replay buffer and limits unacknowledged TLPs to WINDOW. Optional LCRC word after the
//   last data word when TX_LCRC_EN is defined.
// Ports: clk, reset_n (async active-low)
//   tl_valid/tl_sop/tl_eop/tl_data in, tl_ready out  - transaction-layer word handshake
//   buf_ready, busy_n in                              - output stall sources
//   ack_nak, ack_seq in                               - ACK/NAK from the receiver
//   we, seq, dout out                                 - replay buffer write port
//   outstanding out                                   - unacknowledged TLP count
//   err_len, err_ack out                              - one-cycle error pulses
module dll_tx_seq
  import dll_pkg::*;
#(
  parameter int SEQ_W   = dll_pkg::SEQ_W,
  parameter int WINDOW  = 2048,
  parameter int MAX_LEN = 512
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tl_valid,
  input  logic             tl_sop,
  input  logic             tl_eop,
  input  logic [15:0]      tl_data,
  output logic             tl_ready,
  input  logic             buf_ready,
  input  logic             busy_n,
  input  logic [1:0]       ack_nak,
  input  logic [SEQ_W-1:0] ack_seq,
  output logic             we,
  output logic [SEQ_W-1:0] seq,
  output logic [15:0]      dout,
  output logic [SEQ_W-1:0] outstanding,
  output logic             err_len,
  output logic             err_ack
);

  localparam int               CNT_W   = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);
  localparam logic [SEQ_W-1:0] SEQ_ONE = SEQ_W'(1);

  state_e           state_q, state_d;
  logic [SEQ_W-1:0] next_seq_q, next_seq_d;
  logic [SEQ_W-1:0] acked_q, acked_d;
  logic [SEQ_W-1:0] cur_seq_q, cur_seq_d;
  logic [15:0]      data_q, data_d;
  logic             pend_q, pend_d;
  logic             drop_q, drop_d;
  logic             err_len_q, err_len_d;
  logic             err_ack_q, err_ack_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             stall, win_full, accept, is_ack;
  logic [SEQ_W-1:0] ack_dist;
  logic [15:0]      hdr_word;

  assign stall       = ~buf_ready | ~busy_n;
  assign outstanding = next_seq_q - acked_q - SEQ_ONE;
  assign win_full    = int'(outstanding) >= WINDOW;
  assign hdr_word    = 16'(next_seq_q);
  // After a truncated TLP the tail is swallowed outside DATA until its eop arrives.
  assign tl_ready    = ~stall & (drop_q | (state_q == ST_DATA));
  assign accept      = tl_valid & tl_ready;
  assign seq         = cur_seq_q;
  assign err_len     = err_len_q;
  assign err_ack     = err_ack_q;

  // Accepted data words sit one cycle in data_q (pend_q) before being written, so a
  // stall simply holds that word on dout with we low.
`ifdef TX_LCRC_EN
  logic [15:0] crc_q, crc_d, crc_next;

  dll_crc16 u_crc (
    .crc_in  (crc_q),
    .data    ((state_q == ST_HDR) ? hdr_word : data_q),
    .crc_out (crc_next)
  );

  assign we   = ~stall & ((state_q == ST_HDR) | pend_q | (state_q == ST_CRC));
  assign dout = (state_q == ST_HDR) ? hdr_word :
                ((state_q == ST_CRC) && !pend_q) ? crc_q : data_q;
`else
  assign we   = ~stall & ((state_q == ST_HDR) | pend_q);
  assign dout = (state_q == ST_HDR) ? hdr_word : data_q;
`endif

  always_comb begin
    state_d    = state_q;
    next_seq_d = next_seq_q;
    acked_d    = acked_q;
    cur_seq_d  = cur_seq_q;
    data_d     = data_q;
    pend_d     = pend_q;
    drop_d     = drop_q;
    cnt_d      = cnt_q;
    err_len_d  = 1'b0;
    err_ack_d  = 1'b0;
    is_ack     = (ack_nak == AN_ACK) || (ack_nak == AN_NAK);
    ack_dist   = ack_seq - acked_q;
`ifdef TX_LCRC_EN
    crc_d      = crc_q;
    if (we) crc_d = crc_next;
`endif

    if (pend_q && !stall) pend_d = 1'b0;
    if (drop_q && accept && tl_eop) drop_d = 1'b0;

    // ACK bookkeeping runs independently of the output path; a distance of zero is a
    // duplicate and is ignored without an error.
    if (is_ack && (ack_dist != '0)) begin
      if (ack_dist <= outstanding) acked_d   = ack_seq;
      else                         err_ack_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (tl_valid && tl_sop && !stall && !win_full && !drop_q) begin
          state_d   = ST_HDR;
          cur_seq_d = next_seq_q;
          cnt_d     = '0;
`ifdef TX_LCRC_EN
          crc_d     = CRC16_INIT;
`endif
        end
      end
      ST_HDR: begin
        if (!stall) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (accept) begin
          if (cnt_q != MAX_CNT) begin
            pend_d = 1'b1;
            data_d = tl_data;
            cnt_d  = cnt_q + CNT_W'(1);
          end else begin
            // Word MAX_LEN+1: end the TLP here and discard the rest of it.
            err_len_d = 1'b1;
            drop_d    = ~tl_eop;
          end
          if (tl_eop || (cnt_q == MAX_CNT)) begin
`ifdef TX_LCRC_EN
            state_d    = ST_CRC;
`else
            state_d    = ST_IDLE;
            next_seq_d = next_seq_q + SEQ_ONE;
`endif
          end
        end
      end
`ifdef TX_LCRC_EN
      ST_CRC: begin
        // The last data word (if still pending) goes out first, then the CRC word.
        if (!stall && !pend_q) begin
          state_d    = ST_IDLE;
          next_seq_d = next_seq_q + SEQ_ONE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      next_seq_q <= '0;
      acked_q    <= '1;
      cur_seq_q  <= '0;
      data_q     <= '0;
      pend_q     <= 1'b0;
      drop_q     <= 1'b0;
      cnt_q      <= '0;
      err_len_q  <= 1'b0;
      err_ack_q  <= 1'b0;
`ifdef TX_LCRC_EN
      crc_q      <= CRC16_INIT;
`endif
    end else begin
      state_q    <= state_d;
      next_seq_q <= next_seq_d;
      acked_q    <= acked_d;
      cur_seq_q  <= cur_seq_d;
      data_q     <= data_d;
      pend_q     <= pend_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      err_len_q  <= err_len_d;
      err_ack_q  <= err_ack_d;
`ifdef TX_LCRC_EN
      crc_q      <= crc_d;
`endif
    end
  end

endmodule

// File: tb/tb_dll_tx_seq.sv
// tb/tb_dll_tx_seq.sv - scoreboard testbench for dll_tx_seq (TX_LCRC_EN optional)
module tb_dll_tx_seq;
  import dll_pkg::*;

  localparam int SEQ_W   = 12;
  localparam int WINDOW  = 4;
  localparam int MAX_LEN = 3;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             tl_valid, tl_sop, tl_eop, tl_ready;
  logic [15:0]      tl_data;
  logic             buf_ready, busy_n;
  logic [1:0]       ack_nak;
  logic [SEQ_W-1:0] ack_seq;
  logic             we;
  logic [SEQ_W-1:0] seq;
  logic [15:0]      dout;
  logic [SEQ_W-1:0] outstanding;
  logic             err_len, err_ack;

  always #5 clk = ~clk;

  dll_tx_seq #(.SEQ_W(SEQ_W), .WINDOW(WINDOW), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .reset_n(reset_n),
    .tl_valid(tl_valid), .tl_sop(tl_sop), .tl_eop(tl_eop), .tl_data(tl_data),
    .tl_ready(tl_ready), .buf_ready(buf_ready), .busy_n(busy_n),
    .ack_nak(ack_nak), .ack_seq(ack_seq),
    .we(we), .seq(seq), .dout(dout), .outstanding(outstanding),
    .err_len(err_len), .err_ack(err_ack)
  );

  typedef struct packed {
    logic [15:0]      d;
    logic [SEQ_W-1:0] s;
  } exp_t;

  exp_t             exp_q[$];
  int               n_cmp = 0;
  int               n_fail = 0;
  int               n_err_len = 0;
  int               n_err_ack = 0;
  logic [SEQ_W-1:0] m_seq = '0;
  logic [15:0]      wbuf [0:7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 15; i >= 0; i--)
      r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    return r;
  endfunction

  // Monitor: every write to the replay buffer must match the head of the expected queue.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n) begin
      if (err_len) n_err_len++;
      if (err_ack) n_err_ack++;
      if (we) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_we: dout 0x%0h seq 0x%0h with nothing expected", dout, seq);
        end else begin
          e = exp_q.pop_front();
          check("dout", 32'(dout), 32'(e.d));
          check("seq", 32'(seq), 32'(e.s));
        end
      end
    end
  end

  // Expected replay-buffer words for a TLP of n words held in wbuf.
  task automatic push_tlp(input int n);
    logic [15:0] c;
    c = crc_upd(16'hFFFF, 16'(m_seq));
    exp_q.push_back('{d: 16'(m_seq), s: m_seq});
    for (int i = 0; i < n && i < MAX_LEN; i++) begin
      exp_q.push_back('{d: wbuf[i], s: m_seq});
      c = crc_upd(c, wbuf[i]);
    end
`ifdef TX_LCRC_EN
    exp_q.push_back('{d: c, s: m_seq});
`endif
    m_seq = m_seq + 1'b1;
  endtask

  task automatic send_word(input logic sop, input logic eop, input logic [15:0] d);
    bit rdy;
    int t;
    tl_valid = 1'b1; tl_sop = sop; tl_eop = eop; tl_data = d;
    rdy = 1'b0;
    t = 0;
    while (!rdy && t < 200) begin
      @(negedge clk);
      rdy = tl_ready;
      @(posedge clk);
      #1;
      t++;
    end
    tl_valid = 1'b0; tl_sop = 1'b0; tl_eop = 1'b0;
    if (!rdy) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: word 0x%0h not accepted, expected acceptance", d);
    end
  endtask

  task automatic send_tlp(input int n);
    push_tlp(n);
    for (int i = 0; i < n; i++) send_word(i == 0, i == n - 1, wbuf[i]);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d words pending, expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_ack(input logic [1:0] code, input logic [SEQ_W-1:0] s);
    ack_nak = code;
    ack_seq = s;
    @(posedge clk);
    #1;
    ack_nak = AN_NONE;
    ack_seq = '0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int el0, ea0;
    reset_n = 1'b0;
    tl_valid = 1'b0; tl_sop = 1'b0; tl_eop = 1'b0; tl_data = '0;
    buf_ready = 1'b1; busy_n = 1'b1; ack_nak = AN_NONE; ack_seq = '0;
    repeat (3) @(negedge clk);
    check("rst_we", 32'(we), 0);
    check("rst_dout", 32'(dout), 0);
    check("rst_seq", 32'(seq), 0);
    check("rst_tl_ready", 32'(tl_ready), 0);
    check("rst_outstanding", 32'(outstanding), 0);
    check("rst_err", 32'({err_len, err_ack}), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // 1: 3-word TLP, no stall (exactly MAX_LEN words, no truncation)
    wbuf[0] = 16'hA001; wbuf[1] = 16'hA002; wbuf[2] = 16'hA003;
    send_tlp(3);
    drain();
    check("t1_outstanding", 32'(outstanding), 1);

    // 2: busy_n low for 3 cycles after the first data word is accepted
    wbuf[0] = 16'hB001; wbuf[1] = 16'hB002; wbuf[2] = 16'hB003;
    push_tlp(3);
    send_word(1'b1, 1'b0, 16'hB001);
    busy_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_we", 32'(we), 0);
      check("stall_tl_ready", 32'(tl_ready), 0);
      check("stall_dout", 32'(dout), 32'h0000_B001);
    end
    @(posedge clk);
    #1;
    busy_n = 1'b1;
    send_word(1'b0, 1'b0, 16'hB002);
    send_word(1'b0, 1'b1, 16'hB003);
    drain();
    check("t2_outstanding", 32'(outstanding), 2);
    check("t2_no_err_len", 32'(n_err_len), 0);

    // 3: fill the window, 5th TLP held until an ACK frees space
    wbuf[0] = 16'hD002; send_tlp(1); drain();
    wbuf[0] = 16'hD003; send_tlp(1); drain();
    check("win_full_outstanding", 32'(outstanding), 4);
    wbuf[0] = 16'hD004;
    fork
      send_tlp(1);
      begin
        repeat (6) @(negedge clk);
        check("win_block_tl_ready", 32'(tl_ready), 0);
        check("win_block_outstanding", 32'(outstanding), 4);
        @(posedge clk);
        #1;
        ack_nak = AN_ACK; ack_seq = 12'd1;
        @(posedge clk);
        #1;
        ack_nak = AN_NONE; ack_seq = '0;
        @(negedge clk);
        check("ack1_outstanding", 32'(outstanding), 2);
      end
    join
    drain();
    check("t3_outstanding", 32'(outstanding), 3);

    // 5: out-of-window ACK, duplicate, reserved code, then valid NAK/ACK
    ea0 = n_err_ack;
    do_ack(AN_ACK, 12'd11);
    check("bad_ack_err", 32'(n_err_ack - ea0), 1);
    check("bad_ack_outstanding", 32'(outstanding), 3);
    do_ack(AN_NAK, 12'd1);
    do_ack(AN_RSVD, 12'd3);
    check("dup_rsvd_err", 32'(n_err_ack - ea0), 1);
    check("dup_rsvd_outstanding", 32'(outstanding), 3);
    do_ack(AN_NAK, 12'd3);
    check("nak_outstanding", 32'(outstanding), 1);
    do_ack(AN_ACK, 12'd4);
    check("ack4_outstanding", 32'(outstanding), 0);

    // 6: 5-word TLP with MAX_LEN=3 -> 3 words written, err_len once, tail dropped
    el0 = n_err_len;
    wbuf[0] = 16'hC001; wbuf[1] = 16'hC002; wbuf[2] = 16'hC003;
    wbuf[3] = 16'hC004; wbuf[4] = 16'hC005;
    send_tlp(5);
    drain();
    check("trunc_err_len", 32'(n_err_len - el0), 1);
    check("trunc_outstanding", 32'(outstanding), 1);
    do_ack(AN_ACK, 12'd5);
    check("ack5_outstanding", 32'(outstanding), 0);

    // 4: run the sequence number through 4095 and wrap to 0, ACKing each TLP
    ea0 = n_err_ack;
    begin : wrap
      logic [SEQ_W-1:0] s;
      do begin
        s = m_seq;
        wbuf[0] = 16'hE000 | 16'(s);
        send_tlp(1);
        drain();
        do_ack(AN_ACK, s);
      end while (s != '0);
    end
    check("wrap_no_err_ack", 32'(n_err_ack - ea0), 0);
    check("wrap_outstanding", 32'(outstanding), 0);
    check("final_queue_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
